// File: rtl/sga_serial_frame_rx.sv
// sga_serial_frame_rx
//   Serial receiver and frame decoder for the Snake Game Arcade serial link.
//   Line format: 7 data bits LSB first, even parity, 2 stop bits, idle high.
//   A frame is five characters: apple, head, state, flags, '#'. Fields are
//   staged character by character and copied to the outputs only when the
//   closing '#' arrives at index 4, so outputs never update partially.
//
//   Build option: define SGA_RX_PARITY_EN to treat a parity mismatch as a
//   character error. Without it the parity bit is sampled and ignored.
//
// Parameters
//   DIV          clock cycles per serial bit
//   SYNC_STAGES  rx synchronizer depth (values below 2 are raised to 2)
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_serial    serial line, idle high
//   rx_data      last received character
//   rx_valid     one-cycle pulse, rx_data updated
//   apple        apple code of last good frame
//   head         head code of last good frame
//   game_state   main FSM state code of last good frame
//   flags        {comeu_maca, mode, velocity, difficulty} of last good frame
//   frame_valid  one-cycle pulse, fields updated
//   frame_error  one-cycle pulse, frame discarded
//   db_rx_state  receiver FSM state code for the hex display
module sga_serial_frame_rx #(
   parameter int unsigned DIV         = 434,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [6:0] rx_data,
   output logic       rx_valid,
   output logic [5:0] apple,
   output logic [5:0] head,
   output logic [5:0] game_state,
   output logic [3:0] flags,
   output logic       frame_valid,
   output logic       frame_error,
   output logic [2:0] db_rx_state
);

   localparam int unsigned   NSYNC     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned   CW        = $clog2(DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [6:0]    HASH      = 7'h23;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop1  = 3'd4,
      StStop2  = 3'd5,
      StDone   = 3'd6
   } rx_state_e;

   // ---------------------------------------------------------------- input sync
   logic [NSYNC-1:0] sync_q;
   logic [NSYNC-1:0] fill_q;
   logic             rx_s;
   logic             line_ok;

   // fill_q marks when the chain holds real line samples rather than reset ones,
   // so a line held low across reset release is never mistaken for idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[NSYNC-2:0], rx_serial};
         fill_q <= {fill_q[NSYNC-2:0], 1'b1};
      end
   end

   assign rx_s    = sync_q[NSYNC-1];
   assign line_ok = fill_q[NSYNC-1];

   // ---------------------------------------------------------------- receiver
   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [6:0]    shift_q;
   logic          par_q;
   logic          ferr_q;
   logic          armed_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         ferr_q   <= 1'b0;
         armed_q  <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         cnt_q    <= cnt_q + CW'(1);
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               // A start needs a high sample first; armed_q drops when a start is taken.
               if (line_ok && rx_s) begin
                  armed_q <= 1'b1;
               end else if (armed_q && !rx_s) begin
                  armed_q <= 1'b0;
                  ferr_q  <= 1'b0;
                  bit_q   <= '0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q   <= '0;
                  state_q <= rx_s ? StIdle : StData;
               end
            end
            StData: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[6:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd6) begin
                     state_q <= StParity;
                  end
               end
            end
            StParity: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  par_q   <= rx_s;
                  state_q <= StStop1;
               end
            end
            StStop1: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  ferr_q  <= ferr_q | ~rx_s;
                  state_q <= StStop2;
               end
            end
            StStop2: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  ferr_q  <= ferr_q | ~rx_s;
                  state_q <= StDone;
               end
            end
            StDone: begin
               cnt_q    <= '0;
               rx_data  <= shift_q;
               rx_valid <= 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign db_rx_state = state_q;

   // ---------------------------------------------------------------- decoder
   logic       done;
   logic       char_err;
   logic       in_range;
   logic [5:0] code;

   assign done     = (state_q == StDone);
   assign in_range = (shift_q >= 7'h30) && (shift_q <= 7'h6F);
   assign code     = shift_q[5:0] - 6'h30;

`ifdef SGA_RX_PARITY_EN
   // Even parity: ones over data plus parity must be even.
   assign char_err = ferr_q | (^{shift_q, par_q});
`else
   logic unused_par;
   assign unused_par = par_q;
   assign char_err   = ferr_q;
`endif

   logic [2:0] idx_q;
   logic       skip_q;
   logic [5:0] st_apple;
   logic [5:0] st_head;
   logic [5:0] st_state;
   logic [3:0] st_flags;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx_q       <= '0;
         skip_q      <= 1'b0;
         st_apple    <= '0;
         st_head     <= '0;
         st_state    <= '0;
         st_flags    <= '0;
         apple       <= '0;
         head        <= '0;
         game_state  <= '0;
         flags       <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         if (done) begin
            if (char_err) begin
               frame_error <= 1'b1;
               idx_q       <= '0;
            end else if (skip_q) begin
               // Resynchronising after bad content: swallow everything up to '#'.
               if (shift_q == HASH) begin
                  skip_q <= 1'b0;
                  idx_q  <= '0;
               end
            end else if (shift_q == HASH) begin
               idx_q <= '0;
               if (idx_q == 3'd4) begin
                  apple       <= st_apple;
                  head        <= st_head;
                  game_state  <= st_state;
                  flags       <= st_flags;
                  frame_valid <= 1'b1;
               end else begin
                  frame_error <= 1'b1;
               end
            end else if ((idx_q == 3'd4) || !in_range ||
                         ((idx_q == 3'd3) && (shift_q > 7'h3F))) begin
               frame_error <= 1'b1;
               idx_q       <= '0;
               skip_q      <= 1'b1;
            end else begin
               case (idx_q)
                  3'd0:    st_apple <= code;
                  3'd1:    st_head  <= code;
                  3'd2:    st_state <= code;
                  default: st_flags <= code[3:0];
               endcase
               idx_q <= idx_q + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sga_serial_frame_rx.sv
// Bench for sga_serial_frame_rx: directed character tables with hand-derived
// expectations, a few multi-cycle sequences (glitch, reset mid-character), and
// randomized traffic checked against a queue-based frame model.
module tb_sga_serial_frame_rx;

   localparam int unsigned DIV = 24;
`ifdef SGA_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam logic [6:0] HASH = 7'h23;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       rx_serial = 1'b1;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic [5:0] apple;
   logic [5:0] head;
   logic [5:0] game_state;
   logic [3:0] flags;
   logic       frame_valid;
   logic       frame_error;
   logic [2:0] db_rx_state;

   always #5 clock = ~clock;

   sga_serial_frame_rx #(
      .DIV         (DIV),
      .SYNC_STAGES (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_serial   (rx_serial),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .apple       (apple),
      .head        (head),
      .game_state  (game_state),
      .flags       (flags),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .db_rx_state (db_rx_state)
   );

   int checks = 0;
   int errors = 0;
   int n_rx   = 0;
   int n_fv   = 0;
   int n_fe   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   typedef struct {
      bit         valid;
      logic [21:0] fields;
   } ev_t;

   logic [6:0]  exp_rx[$];
   ev_t         exp_ev[$];
   logic [6:0]  pend[$];
   bit          skipping = 1'b0;
   logic [21:0] mdl_fields = '0;

   function automatic bit legal(input logic [6:0] c, input int pos);
      return (c >= 7'h30) && (c <= 7'h6F) && ((pos != 3) || (c <= 7'h3F));
   endfunction

   task automatic model_char(input logic [6:0] c, input bit bad);
      ev_t e;
      logic [6:0] d0, d1, d2, d3;
      e.valid  = 1'b0;
      e.fields = '0;
      exp_rx.push_back(c);
      if (bad) begin
         exp_ev.push_back(e);
         pend.delete();
      end else if (skipping) begin
         if (c == HASH) skipping = 1'b0;
      end else if (c == HASH) begin
         if (pend.size() == 4) begin
            d0 = pend[0] - 7'h30;
            d1 = pend[1] - 7'h30;
            d2 = pend[2] - 7'h30;
            d3 = pend[3] - 7'h30;
            e.valid  = 1'b1;
            e.fields = {d0[5:0], d1[5:0], d2[5:0], d3[3:0]};
         end
         exp_ev.push_back(e);
         pend.delete();
      end else if (pend.size() == 4 || !legal(c, pend.size())) begin
         exp_ev.push_back(e);
         pend.delete();
         skipping = 1'b1;
      end else begin
         pend.push_back(c);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      exp_rx.delete();
      exp_ev.delete();
      skipping   = 1'b0;
      mdl_fields = '0;
   endtask

   // ------------------------------------------------------------ output monitor
   always @(negedge clock) begin
      ev_t e;
      if (frame_valid || frame_error) begin
         if (frame_valid) n_fv++;
         if (frame_error) n_fe++;
         chk("valid_error_exclusive", 32'(frame_valid & frame_error), 32'd0);
         if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_event_unexpected: got valid=%0b error=%0b, expected none",
                     frame_valid, frame_error);
         end else begin
            e = exp_ev.pop_front();
            chk("frame_kind", {30'd0, frame_valid, frame_error}, e.valid ? 32'd2 : 32'd1);
            if (e.valid) mdl_fields = e.fields;
         end
      end
      if (rx_valid) begin
         n_rx++;
         if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got rx_data 0x%0h, expected no character", rx_data);
         end else begin
            chk("rx_data", rx_data, exp_rx.pop_front());
         end
         chk("fields_model", {apple, head, game_state, flags}, mdl_fields);
      end
   end

   // ------------------------------------------------------------ line driver
   task automatic send_char(input logic [6:0] c, input bit stop_bad, input bit par_bad);
      logic [10:0] bits;
      logic        p;
      p    = (^c) ^ par_bad;
      model_char(c, stop_bad || (PAR_EN && par_bad));
      bits = {~stop_bad, 1'b1, p, c, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clock) rx_serial = bits[i];
         repeat (DIV - 1) @(negedge clock);
      end
      if (stop_bad) begin
         @(negedge clock) rx_serial = 1'b1;
         repeat (DIV) @(negedge clock);
      end
   endtask

   // ------------------------------------------------------------ directed table
   typedef struct {
      logic [6:0]  ch;
      bit          stop_bad;
      bit          par_bad;
      int          fv;
      int          fe;
      logic [21:0] fields;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [6:0] ch, input bit sb, input bit pb, input int fv,
                      input int fe, input logic [5:0] a, input logic [5:0] h,
                      input logic [5:0] s, input logic [3:0] f);
      vec_t v;
      v.ch       = ch;
      v.stop_bad = sb;
      v.par_bad  = pb;
      v.fv       = fv;
      v.fe       = fe;
      v.fields   = {a, h, s, f};
      tbl.push_back(v);
   endtask

   task automatic run_tbl(input int lo, input int hi);
      int fv0;
      int fe0;
      for (int i = lo; i <= hi; i++) begin
         fv0 = n_fv;
         fe0 = n_fe;
         send_char(tbl[i].ch, tbl[i].stop_bad, tbl[i].par_bad);
         chk($sformatf("tbl%0d_frame_valid", i), n_fv - fv0, tbl[i].fv);
         chk($sformatf("tbl%0d_frame_error", i), n_fe - fe0, tbl[i].fe);
         chk($sformatf("tbl%0d_fields", i), {apple, head, game_state, flags}, tbl[i].fields);
      end
   endtask

   initial begin
      int         rx0;
      logic [6:0] rc;
      logic [6:0] c;

      // A: clean frame "5C21#" (0-4)
      add(7'h35, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h43, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h32, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h31, 0, 0, 0, 0,  0,  0,  0,  0);
      add(HASH,  0, 0, 1, 0,  5, 19,  2,  1);
      // B: stop-bit error inside a frame, then a clean frame (5-12)
      add(7'h37, 0, 0, 0, 0,  5, 19,  2,  1);
      add(7'h33, 0, 0, 0, 0,  5, 19,  2,  1);
      add(7'h41, 1, 0, 0, 1,  5, 19,  2,  1);
      add(7'h31, 0, 0, 0, 0,  5, 19,  2,  1);
      add(7'h32, 0, 0, 0, 0,  5, 19,  2,  1);
      add(7'h33, 0, 0, 0, 0,  5, 19,  2,  1);
      add(7'h34, 0, 0, 0, 0,  5, 19,  2,  1);
      add(HASH,  0, 0, 1, 0,  1,  2,  3,  4);
      // C: short frame then all-zero frame (13-20)
      add(7'h31, 0, 0, 0, 0,  1,  2,  3,  4);
      add(7'h32, 0, 0, 0, 0,  1,  2,  3,  4);
      add(HASH,  0, 0, 0, 1,  1,  2,  3,  4);
      add(7'h30, 0, 0, 0, 0,  1,  2,  3,  4);
      add(7'h30, 0, 0, 0, 0,  1,  2,  3,  4);
      add(7'h30, 0, 0, 0, 0,  1,  2,  3,  4);
      add(7'h30, 0, 0, 0, 0,  1,  2,  3,  4);
      add(HASH,  0, 0, 1, 0,  0,  0,  0,  0);
      // D: content errors, silent resync, range extremes, missing '#' (21-40)
      add(7'h39, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h7A, 0, 0, 0, 1,  0,  0,  0,  0);
      add(7'h35, 0, 0, 0, 0,  0,  0,  0,  0);
      add(HASH,  0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h31, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h32, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h33, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h40, 0, 0, 0, 1,  0,  0,  0,  0);
      add(HASH,  0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h6F, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h30, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h6F, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h3F, 0, 0, 0, 0,  0,  0,  0,  0);
      add(HASH,  0, 0, 1, 0, 63,  0, 63, 15);
      add(7'h31, 0, 0, 0, 0, 63,  0, 63, 15);
      add(7'h31, 0, 0, 0, 0, 63,  0, 63, 15);
      add(7'h31, 0, 0, 0, 0, 63,  0, 63, 15);
      add(7'h31, 0, 0, 0, 0, 63,  0, 63, 15);
      add(7'h41, 0, 0, 0, 1, 63,  0, 63, 15);
      add(HASH,  0, 0, 0, 0, 63,  0, 63, 15);
      // E: wrong parity on the first character (41-45)
      add(7'h35, 0, 1, 0, PAR_EN ? 1 : 0, 63, 0, 63, 15);
      add(7'h43, 0, 0, 0, 0, 63, 0, 63, 15);
      add(7'h32, 0, 0, 0, 0, 63, 0, 63, 15);
      add(7'h31, 0, 0, 0, 0, 63, 0, 63, 15);
      if (PAR_EN) add(HASH, 0, 0, 0, 1, 63, 0, 63, 15);
      else        add(HASH, 0, 0, 1, 0,  5, 19, 2,  1);
      // F: frame after mid-character reset (46-50)
      add(7'h32, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h34, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h36, 0, 0, 0, 0,  0,  0,  0,  0);
      add(7'h33, 0, 0, 0, 0,  0,  0,  0,  0);
      add(HASH,  0, 0, 1, 0,  2,  4,  6,  3);

      // reset with idle line
      #1 reset = 1'b0;
      repeat (4) @(negedge clock);
      chk("reset_outputs", {rx_data, rx_valid, frame_valid, frame_error, db_rx_state}, 0);
      chk("reset_fields", {apple, head, game_state, flags}, 0);
      reset = 1'b1;
      repeat (2 * DIV) @(negedge clock);
      chk("idle_state", db_rx_state, 0);

      run_tbl(0, 4);

      // short low glitch: enters START, rejected at mid-bit sample
      rx0 = n_rx;
      @(negedge clock) rx_serial = 1'b0;
      repeat (DIV / 3) @(negedge clock);
      chk("glitch_start_seen", db_rx_state, 1);
      rx_serial = 1'b1;
      repeat (3 * DIV) @(negedge clock);
      chk("glitch_no_rx", n_rx - rx0, 0);
      chk("glitch_idle", db_rx_state, 0);
      chk("glitch_fields", {apple, head, game_state, flags}, {6'd5, 6'd19, 6'd2, 4'd1});

      run_tbl(5, 12);
      run_tbl(13, 20);
      run_tbl(21, 40);
      run_tbl(41, 45);

      // reset for 3 cycles in the middle of data bit 3 of 0x35 (that bit is 0)
      rc = 7'h35;
      @(negedge clock) rx_serial = 1'b0;
      repeat (DIV - 1) @(negedge clock);
      for (int b = 0; b < 3; b++) begin
         @(negedge clock) rx_serial = rc[b];
         repeat (DIV - 1) @(negedge clock);
      end
      @(negedge clock) rx_serial = rc[3];
      repeat (DIV / 2) @(negedge clock);
      chk("pre_reset_in_data", db_rx_state, 2);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("midreset_outputs", {rx_data, rx_valid, frame_valid, frame_error, db_rx_state}, 0);
      chk("midreset_fields", {apple, head, game_state, flags}, 0);
      reset = 1'b1;
      model_reset();
      rx0 = n_rx;
      repeat (2 * DIV) @(negedge clock);
      chk("low_after_reset_no_start", db_rx_state, 0);
      chk("low_after_reset_no_rx", n_rx - rx0, 0);
      rx_serial = 1'b1;
      repeat (2 * DIV) @(negedge clock);

      run_tbl(46, 50);

      // randomized traffic against the model
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(3, 0) != 0) begin
            for (int k = 0; k < 4; k++) begin
               c = (k == 3) ? 7'h30 + 7'($urandom_range(15, 0))
                            : 7'h30 + 7'($urandom_range(63, 0));
               send_char(c, $urandom_range(15, 0) == 0, $urandom_range(15, 0) == 0);
            end
            send_char(HASH, $urandom_range(15, 0) == 0, 1'b0);
         end else begin
            for (int k = 0; k < 5; k++) begin
               c = ($urandom_range(4, 0) == 0) ? HASH : 7'($urandom_range(127, 32));
               send_char(c, $urandom_range(15, 0) == 0, 1'b0);
            end
         end
      end

      repeat (2 * DIV) @(negedge clock);
      chk("rx_queue_drained", exp_rx.size(), 0);
      chk("event_queue_drained", exp_ev.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
